// File: rtl/oldland_dbg_engine.sv
// rtl/oldland_dbg_engine.sv - oldland debug command engine: run control, burst memory access, PC breakpoints
module oldland_dbg_engine #(
    parameter int NUM_BKPT  = 4,
    parameter int LEN_BITS  = 8,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [1:0]          cmd_width,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic [31:0]         cmd_addr,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [31:0]         wd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_data,
    output logic                rsp_last,
    output logic                rsp_err,
    output logic                run,
    input  logic                stopped,
    input  logic [31:0]         cpu_pc,
    output logic                dbg_en,
    output logic                mem_access,
    output logic                mem_wr_en,
    output logic [1:0]          mem_width,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_val,
    input  logic [31:0]         mem_rd_val,
    input  logic                mem_compl,
    output logic                bkpt_hit
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_STOP, S_STEP, S_MEM_REQ, S_MEM_WAIT, S_WD_WAIT, S_RSP
    } state_e;

    localparam logic [2:0] OP_HALT = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_RMEM = 3'd3;
    localparam logic [2:0] OP_WMEM = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6, OP_STATUS = 3'd7;
    localparam logic [31:0] NUM_BKPT_W = 32'(NUM_BKPT);

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            width_q, width_d;
    logic [LEN_BITS-1:0]   count_q, count_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  run_q, run_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  hit_flag_q, hit_flag_d;
    logic [2:0]            hit_chan_q, hit_chan_d;
    logic                  dbg_q, dbg_d;
    logic [31:0]           bp_pc_q [NUM_BKPT];
    logic [NUM_BKPT-1:0]   bp_en_q;

    logic                  bp_any, bp_we, bp_set, mem_bad, bp_bad;
    logic [2:0]            hit_idx;
    logic [31:0]           len_ext, align_mask, step_sz;

    // Downward scan so the lowest matching channel wins.
    always_comb begin
        bp_any  = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_BKPT - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_pc_q[i] == cpu_pc)) begin
                bp_any  = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign bkpt_hit   = run_q & bp_any;
    assign len_ext    = {{(32 - LEN_BITS){1'b0}}, cmd_len};
    assign align_mask = (32'd1 << cmd_width) - 32'd1;
    assign mem_bad    = (cmd_width == 2'd3) || ((cmd_addr & align_mask) != 32'd0);
    assign bp_bad     = (len_ext >= NUM_BKPT_W);
    assign step_sz    = 32'd1 << width_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        width_d    = width_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        run_d      = run_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        rsp_err_d  = rsp_err_q;
        hit_flag_d = hit_flag_q;
        hit_chan_d = hit_chan_q;
        dbg_d      = dbg_q;
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        mem_access = 1'b0;
        bp_we      = 1'b0;
        bp_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    width_d    = cmd_width;
                    count_d    = cmd_len;
                    addr_d     = cmd_addr;
                    rsp_data_d = 32'd0;
                    rsp_last_d = 1'b1;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RSP;
                    case (cmd_op)
                        OP_HALT: begin
                            run_d   = 1'b0;
                            state_d = S_WAIT_STOP;
                        end
                        OP_RUN: begin
                            run_d      = 1'b1;
                            hit_flag_d = 1'b0;
                        end
                        OP_STEP: begin
                            run_d   = 1'b1;
                            state_d = S_STEP;
                        end
                        OP_RMEM, OP_WMEM: begin
                            if (mem_bad) begin
                                rsp_err_d = 1'b1;
                            end else if (cmd_op == OP_RMEM) begin
                                dbg_d   = 1'b1;
                                state_d = S_MEM_REQ;
                            end else begin
                                state_d = S_WD_WAIT;
                            end
                        end
                        OP_SETBP, OP_CLRBP: begin
                            if (bp_bad) begin
                                rsp_err_d = 1'b1;
                            end else begin
                                bp_we  = 1'b1;
                                bp_set = (cmd_op == OP_SETBP);
                            end
                        end
                        default: rsp_data_d = {24'd0, hit_chan_q, hit_flag_q, 3'd0, run_q};
                    endcase
                end
            end
            S_WAIT_STOP: begin
                if (stopped) begin
                    rsp_data_d = cpu_pc;
                    state_d    = S_RSP;
                end
            end
            S_STEP: begin
                run_d   = 1'b0;
                state_d = S_WAIT_STOP;
            end
            S_MEM_REQ: begin
                mem_access = 1'b1;
                state_d    = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_compl) begin
                    if (op_q == OP_RMEM) begin
                        rsp_data_d = mem_rd_val;
                        rsp_last_d = (count_q == '0);
                        dbg_d      = (count_q != '0);
                        state_d    = S_RSP;
                    end else if (count_q == '0) begin
                        rsp_data_d = 32'd0;
                        rsp_last_d = 1'b1;
                        dbg_d      = 1'b0;
                        state_d    = S_RSP;
                    end else begin
                        addr_d  = addr_q + step_sz;
                        count_d = count_q - 1'b1;
                        state_d = S_WD_WAIT;
                    end
                end
            end
            S_WD_WAIT: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    wdata_d = wd_data;
                    dbg_d   = 1'b1;
                    state_d = S_MEM_REQ;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    if ((op_q == OP_RMEM) && !rsp_last_q) begin
                        addr_d  = addr_q + step_sz;
                        count_d = count_q - 1'b1;
                        state_d = S_MEM_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A breakpoint hit overrides a RUN accepted in the same cycle.
        if (bkpt_hit) begin
            run_d      = 1'b0;
            hit_flag_d = 1'b1;
            hit_chan_d = hit_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 3'd0;
            width_q    <= 2'd0;
            count_q    <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            run_q      <= RESET_RUN;
            rsp_data_q <= 32'd0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            hit_flag_q <= 1'b0;
            hit_chan_q <= 3'd0;
            dbg_q      <= 1'b0;
            bp_en_q    <= '0;
            for (int i = 0; i < NUM_BKPT; i++) bp_pc_q[i] <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            width_q    <= width_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
            rsp_err_q  <= rsp_err_d;
            hit_flag_q <= hit_flag_d;
            hit_chan_q <= hit_chan_d;
            dbg_q      <= dbg_d;
            if (bp_we) begin
                for (int i = 0; i < NUM_BKPT; i++) begin
                    if (len_ext == 32'(i)) begin
                        bp_en_q[i] <= bp_set;
                        bp_pc_q[i] <= cmd_addr;
                    end
                end
            end
        end
    end

    assign rsp_valid  = (state_q == S_RSP);
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;
    assign run        = run_q;
    assign dbg_en     = dbg_q;
    assign mem_wr_en  = mem_access & (op_q == OP_WMEM);
    assign mem_width  = width_q;
    assign mem_addr   = addr_q;
    assign mem_wr_val = wdata_q;

endmodule

// File: tb/tb_oldland_dbg_engine.sv
// tb/tb_oldland_dbg_engine.sv - self-checking bench for oldland_dbg_engine
module tb_oldland_dbg_engine;

    localparam logic [2:0] OP_HALT = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_RMEM = 3'd3;
    localparam logic [2:0] OP_WMEM = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6, OP_STATUS = 3'd7;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid, cmd_ready, wd_valid, wd_ready, rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [2:0] cmd_op;
    logic [1:0] cmd_width, mem_width;
    logic [7:0] cmd_len;
    logic [31:0] cmd_addr, wd_data, rsp_data, cpu_pc, mem_addr, mem_wr_val, mem_rd_val;
    logic run, stopped, dbg_en, mem_access, mem_wr_en, mem_compl, bkpt_hit;

    always #5 clk = ~clk;

    oldland_dbg_engine #(.NUM_BKPT(4), .LEN_BITS(8), .RESET_RUN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_width(cmd_width), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .run(run), .stopped(stopped),
        .cpu_pc(cpu_pc), .dbg_en(dbg_en), .mem_access(mem_access), .mem_wr_en(mem_wr_en),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wr_val(mem_wr_val),
        .mem_rd_val(mem_rd_val), .mem_compl(mem_compl), .bkpt_hit(bkpt_hit)
    );

    int total = 0, bad = 0, acc_cnt = 0, hit_cnt = 0, run_hi = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [1:0]  width;
    } acc_t;
    acc_t        log_q[$];
    logic [31:0] wd_q[$];

    function automatic logic [31:0] rdv(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: completes each request 1..3 cycles later with address-derived read data.
    initial begin : responder
        acc_t a;
        int extra;
        mem_compl = 1'b0;
        mem_rd_val = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_access === 1'b1 && rst_n) begin
                a.addr = mem_addr; a.wr = mem_wr_en; a.data = mem_wr_val; a.width = mem_width;
                log_q.push_back(a);
                acc_cnt++;
                extra = $urandom_range(0, 2);
                @(posedge clk); #1;
                for (int k = 0; k < extra; k++) begin @(posedge clk); #1; end
                mem_compl = 1'b1;
                mem_rd_val = rdv(a.addr);
                @(posedge clk); #1;
                mem_compl = 1'b0;
            end
        end
    end

    initial begin : wd_feeder
        logic fire;
        wd_valid = 1'b0;
        wd_data = 32'd0;
        forever begin
            @(negedge clk);
            fire = wd_valid && (wd_ready === 1'b1);
            @(posedge clk); #1;
            if (fire) void'(wd_q.pop_front());
            wd_valid = (wd_q.size() > 0);
            wd_data = (wd_q.size() > 0) ? wd_q[0] : 32'd0;
        end
    end

    // Core model: reports stopped three cycles after run drops.
    initial begin : core_model
        logic [2:0] sh;
        sh = 3'd0;
        stopped = 1'b0;
        forever begin
            @(posedge clk); #1;
            sh = {sh[1:0], (run === 1'b0)};
            stopped = sh[2];
        end
    end

    always @(negedge clk) begin
        if (bkpt_hit === 1'b1) hit_cnt++;
        if (run === 1'b1) run_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] w, input logic [7:0] len,
                            input logic [31:0] addr);
        int n;
        n = 0;
        cmd_op = op; cmd_width = w; cmd_len = len; cmd_addr = addr; cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL cmd_accept: got timeout want cmd_ready");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        ok = (n < 300);
        if (!ok) begin
            total++; bad++;
            $display("FAIL rsp_wait: got timeout want rsp_valid");
        end
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] d, output logic l, output logic e);
        logic ok;
        wait_rsp(ok);
        for (int k = 0; k < hold; k++) @(negedge clk);
        d = rsp_data; l = rsp_last; e = rsp_err;
        if (ok) rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
        wd_q.delete();
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  w;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vt[11];
        logic [31:0] d, base, ea, a0;
        logic l, e, ok, run_m, exp_err;
        logic [2:0] op;
        logic [1:0] w;
        logic [7:0] len;
        int n, nbeats;
        logic [31:0] wvals[$];

        cmd_valid = 0; cmd_op = 0; cmd_width = 0; cmd_len = 0; cmd_addr = 0;
        rsp_ready = 0; cpu_pc = 32'h100;
        do_reset();

        @(negedge clk);
        chk("reset_run", run, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_mem_access", mem_access, 0);
        chk("reset_dbg_en", dbg_en, 0);
        chk("reset_bkpt_hit", bkpt_hit, 0);
        @(posedge clk); #1;

        vt[0]  = '{OP_STATUS, 2'd0, 8'd0, 32'h0,         32'h1, 1'b0};
        vt[1]  = '{OP_RMEM,   2'd2, 8'd0, 32'h1002,      32'h0, 1'b1};
        vt[2]  = '{OP_RMEM,   2'd3, 8'd0, 32'h1000,      32'h0, 1'b1};
        vt[3]  = '{OP_WMEM,   2'd1, 8'd0, 32'h3001,      32'h0, 1'b1};
        vt[4]  = '{OP_WMEM,   2'd2, 8'd1, 32'h3002,      32'h0, 1'b1};
        vt[5]  = '{OP_SETBP,  2'd0, 8'd4, 32'h40,        32'h0, 1'b1};
        vt[6]  = '{OP_CLRBP,  2'd0, 8'd7, 32'h0,         32'h0, 1'b1};
        vt[7]  = '{OP_SETBP,  2'd0, 8'd1, 32'h9000_0000, 32'h0, 1'b0};
        vt[8]  = '{OP_CLRBP,  2'd0, 8'd1, 32'h0,         32'h0, 1'b0};
        vt[9]  = '{OP_RMEM,   2'd0, 8'd0, 32'h1003,      rdv(32'h1003), 1'b0};
        vt[10] = '{OP_STATUS, 2'd0, 8'd0, 32'h0,         32'h1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            a0 = acc_cnt;
            send_cmd(vt[i].op, vt[i].w, vt[i].len, vt[i].addr);
            get_rsp(0, d, l, e);
            chk($sformatf("vec%0d_err", i), e, vt[i].exp_err);
            chk($sformatf("vec%0d_last", i), l, 1);
            if (!vt[i].exp_err) chk($sformatf("vec%0d_data", i), d, vt[i].exp_data);
            chk($sformatf("vec%0d_accesses", i), acc_cnt - a0,
                (vt[i].op == OP_RMEM && !vt[i].exp_err) ? 1 : 0);
        end

        // HALT: response arrives once the core reports stopped
        cpu_pc = 32'h100;
        send_cmd(OP_HALT, 0, 0, 0);
        get_rsp(0, d, l, e);
        chk("halt_data", d, 32'h100);
        chk("halt_last", l, 1);
        chk("halt_run", run, 0);

        run_hi = 0;
        send_cmd(OP_STEP, 0, 0, 0);
        get_rsp(0, d, l, e);
        chk("step_run_cycles", run_hi, 1);
        chk("step_data", d, 32'h100);
        chk("step_run_after", run, 0);

        // 4-beat word read with a stalled second beat
        log_q.delete();
        send_cmd(OP_RMEM, 2'd2, 8'd3, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                wait_rsp(ok);
                a0 = acc_cnt;
                for (int k = 0; k < 5; k++) begin
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_data", rsp_data, rdv(32'h1004));
                    chk("stall_dbg_en", dbg_en, 1);
                    @(negedge clk);
                end
                chk("stall_no_access", acc_cnt, a0);
            end
            get_rsp(0, d, l, e);
            chk($sformatf("burst_data%0d", i), d, rdv(32'h1000 + 32'(4 * i)));
            chk($sformatf("burst_last%0d", i), l, (i == 3));
        end
        chk("burst_accesses", log_q.size(), 4);
        for (int i = 0; i < log_q.size() && i < 4; i++)
            chk($sformatf("burst_addr%0d", i), log_q[i].addr, 32'h1000 + 32'(4 * i));
        @(negedge clk);
        chk("burst_dbg_en_done", dbg_en, 0);
        @(posedge clk); #1;

        // Halfword burst write
        log_q.delete();
        wd_q.push_back(32'hAAAA);
        wd_q.push_back(32'h5555);
        send_cmd(OP_WMEM, 2'd1, 8'd1, 32'h2002);
        get_rsp(0, d, l, e);
        chk("wmem_data", d, 0);
        chk("wmem_last", l, 1);
        chk("wmem_err", e, 0);
        n = 0;
        repeat (5) begin @(negedge clk); if (rsp_valid === 1'b1) n++; end
        chk("wmem_single_rsp", n, 0);
        chk("wmem_accesses", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("wmem_addr0", log_q[0].addr, 32'h2002);
            chk("wmem_val0", log_q[0].data, 32'hAAAA);
            chk("wmem_wr0", log_q[0].wr, 1);
            chk("wmem_addr1", log_q[1].addr, 32'h2004);
            chk("wmem_val1", log_q[1].data, 32'h5555);
        end
        @(posedge clk); #1;

        // Breakpoint on channel 2
        cpu_pc = 32'h30;
        send_cmd(OP_SETBP, 0, 8'd2, 32'h40);
        get_rsp(0, d, l, e);
        chk("setbp_err", e, 0);
        send_cmd(OP_RUN, 0, 0, 0);
        get_rsp(0, d, l, e);
        chk("run_data", d, 0);
        hit_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (cpu_pc < 32'h40) cpu_pc = cpu_pc + 32'd4;
        end
        chk("bkpt_pulses", hit_cnt, 1);
        chk("bkpt_run", run, 0);
        send_cmd(OP_STATUS, 0, 0, 0);
        get_rsp(0, d, l, e);
        chk("bkpt_status", d, 32'h50);

        // Reset while beat 2 of a 4-beat read is in flight
        log_q.delete();
        send_cmd(OP_RMEM, 2'd2, 8'd3, 32'h1000);
        get_rsp(0, d, l, e);
        chk("abort_beat1", d, rdv(32'h1000));
        a0 = acc_cnt; n = 0;
        while (acc_cnt == a0 && n < 50) begin @(negedge clk); n++; end
        chk("abort_beat2_started", acc_cnt, a0 + 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_run", run, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = acc_cnt; n = 0; hit_cnt = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid === 1'b1) n++; end
        chk("abort_no_access", acc_cnt, a0);
        chk("abort_no_rsp", n, 0);
        chk("abort_bkpt_cleared", hit_cnt, 0);
        @(posedge clk); #1;
        send_cmd(OP_STATUS, 0, 0, 0);
        get_rsp(0, d, l, e);
        chk("abort_status", d, 32'h1);

        // Randomized commands against a transaction-level model
        do_reset();
        cpu_pc = 32'hFFFF_0000;
        run_m = 1'b1;
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            log_q.delete();
            case (op)
                OP_HALT, OP_STEP: begin
                    send_cmd(op, 0, 0, 0);
                    get_rsp($urandom_range(0, 2), d, l, e);
                    chk("rnd_stop_pc", d, cpu_pc);
                    run_m = 1'b0;
                    chk("rnd_stop_run", run, run_m);
                end
                OP_RUN: begin
                    send_cmd(op, 0, 0, 0);
                    get_rsp($urandom_range(0, 2), d, l, e);
                    chk("rnd_run_data", d, 0);
                    run_m = 1'b1;
                end
                OP_STATUS: begin
                    send_cmd(op, 0, 0, 0);
                    get_rsp($urandom_range(0, 2), d, l, e);
                    chk("rnd_status", d, {31'd0, run_m});
                end
                OP_SETBP, OP_CLRBP: begin
                    len = 8'($urandom_range(0, 5));
                    send_cmd(op, 0, len, $urandom & 32'h0FFF_FFFC);
                    get_rsp(0, d, l, e);
                    chk("rnd_bp_err", e, (len >= 4));
                    chk("rnd_bp_last", l, 1);
                end
                default: begin
                    w = 2'($urandom_range(0, 3));
                    len = 8'($urandom_range(0, 3));
                    base = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFF0);
                    if ($urandom_range(0, 3) == 0) base = base | 32'($urandom_range(1, 3));
                    exp_err = (w == 2'd3) || ((base % (32'd1 << w)) != 0);
                    nbeats = int'(len) + 1;
                    wvals.delete();
                    if (op == OP_WMEM && !exp_err)
                        for (int i = 0; i < nbeats; i++) begin
                            wvals.push_back($urandom);
                            wd_q.push_back(wvals[i]);
                        end
                    send_cmd(op, w, len, base);
                    if (exp_err) begin
                        get_rsp(0, d, l, e);
                        chk("rnd_mem_err", e, 1);
                        chk("rnd_mem_err_last", l, 1);
                        chk("rnd_mem_err_noacc", log_q.size(), 0);
                    end else begin
                        if (op == OP_RMEM) begin
                            for (int i = 0; i < nbeats; i++) begin
                                get_rsp($urandom_range(0, 2), d, l, e);
                                ea = base + 32'(i) * (32'd1 << w);
                                chk("rnd_rd_data", d, rdv(ea));
                                chk("rnd_rd_last", l, (i == nbeats - 1));
                            end
                        end else begin
                            get_rsp(0, d, l, e);
                            chk("rnd_wr_rsp", {d[30:0], l}, 32'h1);
                        end
                        chk("rnd_accesses", log_q.size(), nbeats);
                        for (int i = 0; i < log_q.size() && i < nbeats; i++) begin
                            ea = base + 32'(i) * (32'd1 << w);
                            chk("rnd_acc_addr", log_q[i].addr, ea);
                            chk("rnd_acc_kind", {log_q[i].wr, log_q[i].width}, {(op == OP_WMEM), w});
                            if (op == OP_WMEM) chk("rnd_acc_wdata", log_q[i].data, wvals[i]);
                        end
                    end
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
